// File: rtl/a2d_scan_sched_pkg.sv
// Shared types and constants for the A2D conversion scheduler.
// A2D_SCHED_AVG_EN (when defined) enables 4-sample averaging of scan slots.
package a2d_sched_pkg;
  localparam int NUM_CH    = 8;
  localparam int CH_W      = 3;
  localparam int RES_W     = 12;
  localparam int AVG_CNT   = 4;
  localparam int AVG_SHIFT = 2;
  localparam int ACC_W     = RES_W + AVG_SHIFT;

  typedef enum logic [2:0] {IDLE, PICK, CONV, WAIT, STORE} state_t;
  typedef enum logic {SCAN, REQ} mode_t;

  // MSB flags "found"; low bits give the index of the lowest set bit.
  function automatic logic [CH_W:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = {1'b1, CH_W'(i)};
    end
  endfunction
endpackage

// File: rtl/a2d_scan_sched_if.sv
// Handshake between the scheduler (master) and the SPI A2D interface (slave).
interface a2d_scan_sched_if;
  import a2d_sched_pkg::*;
  logic             strt_cnv;
  logic [CH_W-1:0]  chnnl;
  logic             cnv_cmplt;
  logic [RES_W-1:0] res;

  modport master (output strt_cnv, chnnl, input cnv_cmplt, res);
  modport slave  (input strt_cnv, chnnl, output cnv_cmplt, res);
endinterface

// File: rtl/a2d_scan_sched_period_tmr.sv
// Scan-period timer: counts while enabled, pulses expire on count == period.
module a2d_period_tmr #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_en,
  input  logic [PER_W-1:0] period,
  output logic             expire
);
  logic [PER_W-1:0] cnt_reg;

  assign expire = scan_en && (cnt_reg == period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_reg <= '0;
    else if (!scan_en || expire) cnt_reg <= '0;
    else                         cnt_reg <= cnt_reg + 1'b1;
  end
endmodule

// File: rtl/a2d_scan_sched.sv
// Conversion scheduler: periodic masked channel scans plus prioritised one-shot requests.
// A2D_SCHED_AVG_EN: each scan slot averages 4 conversions (truncated mean).
module a2d_scan_sched
  import a2d_sched_pkg::*;
#(
  parameter int PER_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_en,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [PER_W-1:0]   period,
  input  logic               req,
  input  logic [CH_W-1:0]    req_ch,
  output logic               req_done,
  output logic [RES_W-1:0]   req_res,
  a2d_scan_sched_if.master   a2d,
  input  logic [CH_W-1:0]    rd_ch,
  output logic [RES_W-1:0]   rd_res,
  output logic               rd_vld,
  output logic               scan_done,
  output logic               ovr,
  output logic               busy
);
  state_t             state_reg, state_next;
  mode_t              mode_reg;
  logic [CH_W-1:0]    cur_ch_reg, req_ch_reg;
  logic               req_pend_reg, scan_pend_reg, scan_act_reg;
  logic [NUM_CH-1:0]  scan_mask_reg, valid_reg, elig;
  logic [CH_W:0]      ptr_reg, hit;
  logic               ovr_reg, scan_done_reg, req_done_reg;
  logic [RES_W-1:0]   req_res_reg, store_val;
  logic [RES_W-1:0]   result_mem [NUM_CH];
  logic               expire, take_scan, pick_req, pick_scan, end_scan, store_en, last_conv;

  a2d_period_tmr #(.PER_W(PER_W)) u_tmr (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .period(period), .expire(expire)
  );

  // A channel is eligible if masked in and not yet visited in this scan.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_elig
    assign elig[gi] = scan_mask_reg[gi] && (ptr_reg <= (CH_W+1)'(gi));
  end
  assign hit = lowest_set(elig);

`ifdef A2D_SCHED_AVG_EN
  logic [1:0]       avg_cnt_reg;
  logic [ACC_W-1:0] acc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_cnt_reg <= '0;
      acc_reg     <= '0;
    end else if (state_reg == PICK) begin
      avg_cnt_reg <= '0;
      acc_reg     <= '0;
    end else if (state_reg == WAIT && a2d.cnv_cmplt && mode_reg == SCAN) begin
      avg_cnt_reg <= avg_cnt_reg + 2'd1;
      acc_reg     <= acc_reg + ACC_W'(a2d.res);
    end
  end

  assign last_conv = (mode_reg == REQ) || (avg_cnt_reg == 2'(AVG_CNT - 1));
  assign store_val = (mode_reg == SCAN) ? acc_reg[ACC_W-1:AVG_SHIFT] : a2d.res;
`else
  assign last_conv = 1'b1;
  assign store_val = a2d.res;
`endif

  always_comb begin
    state_next = state_reg;
    take_scan  = 1'b0;
    pick_req   = 1'b0;
    pick_scan  = 1'b0;
    end_scan   = 1'b0;
    store_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_pend_reg) begin
          state_next = PICK;
        end else if (scan_pend_reg) begin
          take_scan  = 1'b1;
          state_next = PICK;
        end
      end
      PICK: begin
        if (req_pend_reg) begin
          pick_req   = 1'b1;
          state_next = CONV;
        end else if (scan_act_reg && hit[CH_W]) begin
          pick_scan  = 1'b1;
          state_next = CONV;
        end else begin
          end_scan   = scan_act_reg;
          state_next = IDLE;
        end
      end
      CONV:  state_next = WAIT;
      WAIT:  if (a2d.cnv_cmplt) state_next = last_conv ? STORE : CONV;
      STORE: begin
        store_en   = 1'b1;
        state_next = PICK;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg      <= SCAN;
      cur_ch_reg    <= '0;
      req_ch_reg    <= '0;
      req_pend_reg  <= 1'b0;
      scan_pend_reg <= 1'b0;
      scan_act_reg  <= 1'b0;
      scan_mask_reg <= '0;
      ptr_reg       <= '0;
      ovr_reg       <= 1'b0;
      scan_done_reg <= 1'b0;
      req_done_reg  <= 1'b0;
      req_res_reg   <= '0;
      valid_reg     <= '0;
      for (int i = 0; i < NUM_CH; i++) result_mem[i] <= '0;
    end else begin
      scan_done_reg <= end_scan;
      req_done_reg  <= store_en && (mode_reg == REQ);

      // Only one request may be outstanding; extras are dropped.
      if (req && !req_pend_reg) begin
        req_pend_reg <= 1'b1;
        req_ch_reg   <= req_ch;
      end else if (store_en && mode_reg == REQ) begin
        req_pend_reg <= 1'b0;
      end

      if (!scan_en) begin
        scan_pend_reg <= 1'b0;
        ovr_reg       <= 1'b0;
      end else begin
        if (expire)         scan_pend_reg <= 1'b1;
        else if (take_scan) scan_pend_reg <= 1'b0;
        if (expire && (scan_pend_reg || scan_act_reg)) ovr_reg <= 1'b1;
      end

      if (take_scan) begin
        scan_mask_reg <= ch_mask;
        ptr_reg       <= '0;
        scan_act_reg  <= 1'b1;
      end else if (end_scan) begin
        scan_act_reg  <= 1'b0;
      end

      if (pick_req) begin
        cur_ch_reg <= req_ch_reg;
        mode_reg   <= REQ;
      end else if (pick_scan) begin
        cur_ch_reg <= hit[CH_W-1:0];
        mode_reg   <= SCAN;
      end

      if (store_en) begin
        result_mem[cur_ch_reg] <= store_val;
        valid_reg[cur_ch_reg]  <= 1'b1;
        if (mode_reg == REQ) req_res_reg <= a2d.res;
        else                 ptr_reg     <= (CH_W+1)'(cur_ch_reg) + 1'b1;
      end
    end
  end

  assign a2d.strt_cnv = (state_reg == CONV);
  assign a2d.chnnl    = cur_ch_reg;
  assign busy         = (state_reg != IDLE);
  assign rd_res       = result_mem[rd_ch];
  assign rd_vld       = valid_reg[rd_ch];
  assign scan_done    = scan_done_reg;
  assign req_done     = req_done_reg;
  assign req_res      = req_res_reg;
  assign ovr          = ovr_reg;
endmodule

// File: tb/tb_a2d_scan_sched.sv
// Directed bench for a2d_scan_sched with an A2D model and conversion/request scoreboards.
module tb_a2d_scan_sched;
  import a2d_sched_pkg::*;

`ifdef A2D_SCHED_AVG_EN
  localparam int AVG = 4;
  localparam logic [11:0] EXP_TAB_RES = 12'h101;
`else
  localparam int AVG = 1;
  localparam logic [11:0] EXP_TAB_RES = 12'h100;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic [7:0]  ch_mask;
  logic [15:0] period;
  logic        req;
  logic [2:0]  req_ch;
  logic        req_done;
  logic [11:0] req_res;
  logic [2:0]  rd_ch;
  logic [11:0] rd_res;
  logic        rd_vld, scan_done, ovr, busy;

  a2d_scan_sched_if a2d ();

  a2d_scan_sched #(.PER_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask), .period(period),
    .req(req), .req_ch(req_ch), .req_done(req_done), .req_res(req_res), .a2d(a2d),
    .rd_ch(rd_ch), .rd_res(rd_res), .rd_vld(rd_vld), .scan_done(scan_done),
    .ovr(ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;
  int cyc = 0, n_strt = 0, last_strt_cyc = 0, n_req_done = 0, scan_done_cnt = 0;
  int mdl_lat = 5, mdl_cnt = 0, tab_idx = 0;
  bit use_tab = 1'b0;
  logic [2:0]  mdl_ch = '0;
  logic [11:0] avg_tab [4] = '{12'h100, 12'h101, 12'h102, 12'h104};
  int          exp_ch_q [$];
  logic [11:0] exp_res_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_scan(input int ch);
    for (int i = 0; i < AVG; i++) exp_ch_q.push_back(ch);
  endtask

  // A2D model plus monitors, evaluated on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      a2d.cnv_cmplt = 1'b0;
      a2d.res       = '0;
      mdl_cnt       = 0;
    end else begin
      if (a2d.strt_cnv) begin
        n_strt++;
        last_strt_cyc = cyc;
        if (exp_ch_q.size() == 0) check("unexp_strt", a2d.strt_cnv, 1'b0);
        else check("conv_ch", a2d.chnnl, exp_ch_q.pop_front());
        a2d.cnv_cmplt = 1'b0;
        mdl_cnt       = mdl_lat;
        mdl_ch        = a2d.chnnl;
      end else if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          a2d.cnv_cmplt = 1'b1;
          if (use_tab) begin
            a2d.res = avg_tab[tab_idx];
            tab_idx = (tab_idx + 1) % 4;
          end else begin
            a2d.res = 12'h100 + {9'b0, mdl_ch};
          end
        end
      end
      if (req_done) begin
        n_req_done++;
        $display("req_done res=%0h", req_res);
        if (exp_res_q.size() == 0) check("unexp_req_done", req_done, 1'b0);
        else check("req_res", req_res, exp_res_q.pop_front());
      end
      if (scan_done) scan_done_cnt++;
    end
  end

  task automatic wait_strt(input int target, input int maxc);
    for (int i = 0; i < maxc && n_strt < target; i++) tick();
    check("strt_seen", (n_strt >= target), 1'b1);
  endtask

  task automatic wait_scan(input int target, input int maxc);
    for (int i = 0; i < maxc && scan_done_cnt < target; i++) tick();
    check("scan_done_cnt", scan_done_cnt, target);
  endtask

  task automatic wait_req(input int target, input int maxc);
    for (int i = 0; i < maxc && n_req_done < target; i++) tick();
    check("req_done_cnt", n_req_done, target);
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy; i++) tick();
    check("idle", busy, 1'b0);
  endtask

  initial begin
    int drv_cyc, sd0, n0;
    rst_n = 1'b0; scan_en = 1'b0; ch_mask = '0; period = '0;
    req = 1'b0; req_ch = '0; rd_ch = '0;
    a2d.cnv_cmplt = 1'b0; a2d.res = '0;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_strt", a2d.strt_cnv, 1'b0);
    check("rst_req_done", req_done, 1'b0);
    check("rst_scan_done", scan_done, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    check("rst_chnnl", a2d.chnnl, 3'd0);
    check("rst_req_res", req_res, 12'h0);
    check("rst_rd_vld", rd_vld, 1'b0);
    check("rst_rd_res", rd_res, 12'h0);
    rst_n = 1'b1;
    tick();

    // One-shot request from idle, scanning disabled.
    exp_ch_q.push_back(6);
    exp_res_q.push_back(12'h106);
    req = 1'b1; req_ch = 3'd6; drv_cyc = cyc;
    tick();
    req = 1'b0;
    wait_req(1, 200);
    check("req_latency", last_strt_cyc - drv_cyc, 3);
    rd_ch = 3'd6; #1;
    check("rd_res6", rd_res, 12'h106);
    check("rd_vld6", rd_vld, 1'b1);

    // Masked scan of channels 0, 5, 7.
    push_scan(0); push_scan(5); push_scan(7);
    ch_mask = 8'b1010_0001; period = 16'd200; scan_en = 1'b1;
    wait_scan(1, 1000);
    scan_en = 1'b0;
    rd_ch = 3'd5; #1;
    check("rd_res5", rd_res, 12'h105);
    rd_ch = 3'd3; #1;
    check("rd_vld3", rd_vld, 1'b0);
    check("scan_ovr", ovr, 1'b0);
    check("scan_q_empty", exp_ch_q.size(), 0);

    // Request inserted during channel 0 WAIT; a second request is dropped.
    push_scan(0); exp_ch_q.push_back(2); push_scan(5); push_scan(7);
    exp_res_q.push_back(12'h102);
    n0 = n_strt;
    tick();
    scan_en = 1'b1;
    wait_strt(n0 + 1, 500);
    tick(); tick();
    req = 1'b1; req_ch = 3'd2; tick();
    req = 1'b0; tick();
    req = 1'b1; req_ch = 3'd4; tick();
    req = 1'b0;
    wait_scan(2, 1000);
    scan_en = 1'b0;
    check("mid_req_done_cnt", n_req_done, 2);
    rd_ch = 3'd4; #1;
    check("dropped_vld4", rd_vld, 1'b0);
    rd_ch = 3'd2; #1;
    check("rd_res2", rd_res, 12'h102);
    check("mid_q_empty", exp_ch_q.size(), 0);

    // Overrun: short period, slow converter.
    mdl_lat = 40;
    push_scan(0);
    ch_mask = 8'b0000_0001; period = 16'd10;
    tick();
    scan_en = 1'b1;
    repeat (5) tick();
    check("ovr_early", ovr, 1'b0);
    repeat (25) tick();
    check("ovr_set", ovr, 1'b1);
    scan_en = 1'b0;
    tick();
    check("ovr_clr", ovr, 1'b0);
    wait_idle(600);
    check("ovr_q_empty", exp_ch_q.size(), 0);
    check("ovr_scan_cnt", scan_done_cnt, 3);
    mdl_lat = 5;

    // Empty mask, back-to-back period.
    ch_mask = '0; period = '0;
    sd0 = scan_done_cnt; n0 = n_strt;
    scan_en = 1'b1;
    repeat (40) tick();
    scan_en = 1'b0;
    wait_idle(50);
    check("empty_scan_done", (scan_done_cnt - sd0 >= 10), 1'b1);
    check("empty_no_strt", n_strt, n0);

    // Asynchronous reset during WAIT.
    exp_ch_q.push_back(3);
    n0 = n_strt;
    req = 1'b1; req_ch = 3'd3; tick();
    req = 1'b0;
    wait_strt(n0 + 1, 50);
    tick();
    rst_n = 1'b0; #1;
    rd_ch = 3'd6; #1;
    check("arst_busy", busy, 1'b0);
    check("arst_chnnl", a2d.chnnl, 3'd0);
    check("arst_strt", a2d.strt_cnv, 1'b0);
    check("arst_rd_vld", rd_vld, 1'b0);
    check("arst_rd_res", rd_res, 12'h0);
    check("arst_req_res", req_res, 12'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // After reset the first conversion waits for the first period expiry.
    use_tab = 1'b1; tab_idx = 0;
    push_scan(0);
    ch_mask = 8'b0000_0001; period = 16'd60;
    sd0 = scan_done_cnt; n0 = n_strt;
    drv_cyc = cyc;
    scan_en = 1'b1;
    wait_strt(n0 + 1, 200);
    check("first_expiry_lat", last_strt_cyc - drv_cyc, 63);
    wait_scan(sd0 + 1, 400);
    scan_en = 1'b0;
    rd_ch = 3'd0; #1;
    check("tab_res0", rd_res, EXP_TAB_RES);
    check("tab_strt_cnt", n_strt - n0, AVG);
    wait_idle(50);
    check("final_ch_q", exp_ch_q.size(), 0);
    check("final_res_q", exp_res_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/a2d_scan_sched.md
Name: a2d_scan_sched

Overview:
- Autonomous conversion scheduler in front of the SPI A2D interface block.
- Periodically scans an enabled subset of the 8 A2D channels, one conversion at a time, and stores the latest 12-bit result per channel.
- Services one-shot host requests for a single channel. Requests are interleaved between scan conversions with priority.
- Sole driver of the A2D interface's strt_cnv/chnnl; consumers read results from the register file, not from the interface.

Parameters:
- NUM_CH, 8, number of channels scanned; fixed by the 3-bit channel field.
- RES_W, 12, result width.
- PER_W, 16, width of the scan-period counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- scan_en  in  1  level; enables periodic scanning
- ch_mask  in  8  per-channel scan enable (bit i = channel i)
- period  in  PER_W  clocks between scan starts; 0 = back-to-back
- req  in  1  one-cycle host request pulse
- req_ch  in  3  channel for req
- req_done  out  1  one-cycle pulse; req_res valid this cycle
- req_res  out  12  result of the serviced request
- strt_cnv  out  1  one-cycle start pulse to the A2D interface
- chnnl  out  3  channel to the A2D interface
- cnv_cmplt  in  1  level from the A2D interface; clears after strt_cnv
- res  in  12  conversion result from the A2D interface
- rd_ch  in  3  result-file read select
- rd_res  out  12  combinational read of result[rd_ch]
- rd_vld  out  1  result[rd_ch] written since reset
- scan_done  out  1  one-cycle pulse at end of each scan
- ovr  out  1  sticky; period expired while a scan was still running
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - state IDLE.
  - strt_cnv, req_done, scan_done, ovr, busy = 0.
  - chnnl = 0, req_res = 0.
  - All result regs = 0; valid bits = 0; timer = 0; pending flags = 0.
- Period timer:
  - While scan_en=1, counts up each clock.
  - On count == period: sets scan_pend and reloads to 0.
  - If scan_pend is already set, or a scan is active, at expiry: ovr <= 1.
  - scan_en=0: timer held at 0, scan_pend cleared, ovr cleared. An in-progress scan finishes.
- Request latch:
  - req=1 with req_pend=0: req_pend <= 1 and req_ch is captured.
  - req while req_pend=1: ignored, request dropped.
- FSM IDLE:
  - req_pend → PICK.
  - Else scan_pend → clear scan_pend, capture ch_mask into scan_mask, set scan pointer to 0, → PICK.
  - When both are pending, the request wins.
- FSM PICK (1 cycle):
  - req_pend → cur_ch = latched req channel, mode = REQ.
  - Else if a scan is active and a scan_mask bit exists at index ≥ pointer → cur_ch = lowest such index, mode = SCAN.
  - Else, if a scan is active → pulse scan_done, end the scan, → IDLE.
  - Else → IDLE.
  - A scan_mask of 0 yields scan_done 1 cycle after PICK, with no conversions.
- FSM CONV (1 cycle): strt_cnv = 1; chnnl = cur_ch; → WAIT.
- FSM WAIT:
  - chnnl held stable.
  - cnv_cmplt is sampled from the cycle after strt_cnv; it must already be 0 there.
  - cnv_cmplt=1 → STORE.
  - No timeout.
- FSM STORE (1 cycle):
  - result[cur_ch] <= res; valid[cur_ch] <= 1.
  - mode REQ: req_res <= res; req_done pulses the following cycle, aligned with req_res; clear req_pend.
  - mode SCAN: pointer <= cur_ch + 1.
  - Then → PICK.
- Pointer wrap: pointer reaching 8 means no channels remain; this is the end-of-scan case, with no wrap to 0.
- Simultaneous events:
  - A request arriving mid-scan is inserted at the next PICK.
  - A write to rd_ch in STORE is visible on rd_res the next cycle.
- Minimum request latency, req to strt_cnv: 3 cycles from IDLE (latch, PICK, CONV).

Optional Feature:
- Macro A2D_SCHED_AVG_EN.
- Defined: each SCAN slot performs 4 back-to-back conversions on cur_ch, through the CONV/WAIT loop with a 2-bit count, into a 14-bit accumulator cleared at PICK.
  - Stored value = acc[13:2], i.e. truncated mean.
  - REQ slots remain single-conversion.
  - A pending request waits until all 4 conversions of the current channel finish.
- Undefined: one conversion per slot; no accumulator or counter.

Decomposition:
- Package a2d_sched_pkg:
  - state enum {IDLE, PICK, CONV, WAIT, STORE}.
  - mode enum {SCAN, REQ}.
  - NUM_CH, RES_W, AVG_CNT=4, AVG_SHIFT=2.
- One sub-module, a2d_period_tmr: period counter, expiry pulse, reload and scan_en gating.

Test Plan:
- ch_mask=8'b1010_0001, period=200, model returns res=0x100+ch → conversions on channels 0, 5, 7 in order; result[5]=0x105; scan_done once per scan; rd_vld(3)=0.
- Idle, req=1 with req_ch=6 and scan_en=0 → strt_cnv 3 cycles later with chnnl=6; req_done with req_res=0x106; result[6]=0x106.
- Mid-scan, during channel 0's WAIT, req on channel 2 → order 0, 2(REQ), 5, 7; a second req before the first req_done is dropped.
- period=10 with a slow model (conversion ~40 cycles) → ovr=1 after the first expiry during the scan; scan_en=0 clears ovr.
- ch_mask=0, period=0 → scan_done pulses repeatedly; strt_cnv never asserted.
- rst_n low during WAIT → all outputs at reset values immediately. After release, with scan_en=1, the first strt_cnv follows the first period expiry. With A2D_SCHED_AVG_EN and res 0x100, 0x101, 0x102, 0x104 on channel 0: 4 strt_cnv pulses, result[0]=0x101.
